// File: rtl/dmem_access_ctrl_pkg.sv
// rtl/dmem_access_ctrl_pkg.sv - shared FSM state encoding for the data-memory access controller
package dmem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        DMEM_IDLE = 2'd0,
        DMEM_ADDR = 2'd1,
        DMEM_DATA = 2'd2,
        DMEM_DONE = 2'd3
    } dmem_state_t;

endpackage

// File: rtl/dmem_access_ctrl.sv
// rtl/dmem_access_ctrl.sv - MEM-stage load/store to SRAM-like bus controller, producer of data_stall_M
// Optional read-data forwarding on data_ok: DMEM_RDATA_FWD_EN
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_en_M,
    input  logic [3:0]        mem_wen_M,
    input  logic [1:0]        mem_size_M,
    input  logic [ADDR_W-1:0] mem_addr_M,
    input  logic [DATA_W-1:0] mem_wdata_M,
    input  logic              except_M,
    input  logic              ext_stall,
    output logic              data_stall_M,
    output logic [DATA_W-1:0] mem_rdata_M,
    output logic              data_req,
    output logic              data_wr,
    output logic [1:0]        data_size,
    output logic [ADDR_W-1:0] data_addr,
    output logic [DATA_W-1:0] data_wdata,
    input  logic              data_addr_ok,
    input  logic              data_data_ok,
    input  logic [DATA_W-1:0] data_rdata
);

    dmem_state_t       r_state;
    dmem_state_t       w_next;
    logic              r_wr;
    logic [1:0]        r_size;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_q;
    logic              w_issue;
    logic              w_fwd;
    logic              w_stall;

    assign w_issue = mem_en_M & ~except_M;

`ifdef DMEM_RDATA_FWD_EN
    // Completing with no external stall lets the pipeline advance in the data_ok cycle itself.
    assign w_fwd = (r_state == DMEM_DATA) & data_data_ok & ~ext_stall;
`else
    assign w_fwd = 1'b0;
`endif

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            DMEM_IDLE: begin
                w_stall = w_issue;
                if (w_issue) w_next = DMEM_ADDR;
            end
            DMEM_ADDR: begin
                w_stall = 1'b1;
                if (data_addr_ok) w_next = DMEM_DATA;
            end
            DMEM_DATA: begin
                w_stall = 1'b1;
                if (data_data_ok) begin
                    if (w_fwd) begin
                        w_stall = 1'b0;
                        w_next  = DMEM_IDLE;
                    end else begin
                        w_next  = DMEM_DONE;
                    end
                end
            end
            DMEM_DONE: begin
                if (!ext_stall) w_next = DMEM_IDLE;
            end
            default: w_next = DMEM_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state   <= DMEM_IDLE;
            r_wr      <= 1'b0;
            r_size    <= 2'd0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_rdata_q <= '0;
        end else begin
            r_state <= w_next;
            // Request fields are frozen for the whole ADDR phase so the bus sees stable values.
            if (r_state == DMEM_IDLE && w_issue) begin
                r_wr    <= |mem_wen_M;
                r_size  <= mem_size_M;
                r_addr  <= mem_addr_M;
                r_wdata <= mem_wdata_M;
            end
            if (r_state == DMEM_DATA && data_data_ok && !r_wr) begin
                r_rdata_q <= data_rdata;
            end
        end
    end

    assign data_stall_M = w_stall;
    assign data_req     = (r_state == DMEM_ADDR);
    assign data_wr      = r_wr;
    assign data_size    = r_size;
    assign data_addr    = r_addr;
    assign data_wdata   = r_wdata;
    assign mem_rdata_M  = w_fwd ? data_rdata : r_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// tb/tb_dmem_access_ctrl.sv - self-checking bench for dmem_access_ctrl (table vectors plus random accesses)
module tb_dmem_access_ctrl;

`ifdef DMEM_RDATA_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_en_M;
    logic [3:0]  mem_wen_M;
    logic [1:0]  mem_size_M;
    logic [31:0] mem_addr_M;
    logic [31:0] mem_wdata_M;
    logic        except_M;
    logic        ext_stall;
    logic        data_stall_M;
    logic [31:0] mem_rdata_M;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    dmem_access_ctrl #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .mem_en_M     (mem_en_M),
        .mem_wen_M    (mem_wen_M),
        .mem_size_M   (mem_size_M),
        .mem_addr_M   (mem_addr_M),
        .mem_wdata_M  (mem_wdata_M),
        .except_M     (except_M),
        .ext_stall    (ext_stall),
        .data_stall_M (data_stall_M),
        .mem_rdata_M  (mem_rdata_M),
        .data_req     (data_req),
        .data_wr      (data_wr),
        .data_size    (data_size),
        .data_addr    (data_addr),
        .data_wdata   (data_wdata),
        .data_addr_ok (data_addr_ok),
        .data_data_ok (data_data_ok),
        .data_rdata   (data_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          en;
        bit          exc;
        logic [3:0]  wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        int          ad;
        int          dd;
        int          es;
    } vec_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [31:0] m_rdata_q = 32'h0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_fields(input vec_t v);
        mem_wen_M   = v.wen;
        mem_size_M  = v.size;
        mem_addr_M  = v.addr;
        mem_wdata_M = v.wdata;
    endtask

    // Expected behaviour derived from transaction-level timing: one IDLE cycle, ad+1 ADDR cycles,
    // dd+1 DATA cycles, then es+1 DONE cycles (or none when forwarding completes without ext_stall).
    task automatic run_vec(input vec_t v);
        bit issue     = v.en && !v.exc;
        bit wr        = |v.wen;
        int t_ok      = 2 + v.ad + v.dd;
        bit skip_done = FWD && (v.es == 0);
        int n_done    = skip_done ? 0 : v.es + 1;
        int total     = t_ok + 1 + n_done;
        int stalls    = 0;
        int reqs      = 0;
        logic [31:0] new_q = wr ? m_rdata_q : v.rdata;
        if (!issue) begin
            @(posedge clk); #1;
            mem_en_M = v.en; except_M = v.exc; drive_fields(v);
            data_addr_ok = 1'($urandom % 2); data_data_ok = 1'($urandom % 2);
            ext_stall = 1'($urandom % 2); data_rdata = $urandom;
            @(negedge clk);
            chk("noissue_stall", data_stall_M, 0);
            chk("noissue_req", data_req, 0);
            chk("noissue_rdata", mem_rdata_M, m_rdata_q);
            return;
        end
        for (int k = 0; k < total; k++) begin
            @(posedge clk); #1;
            mem_en_M = 1'b1;
            except_M = (k == 0) ? 1'b0 : 1'($urandom % 4 == 0);
            drive_fields(v);
            if (k == 1 + v.ad)                data_addr_ok = 1'b1;
            else if (k >= 1 && k < 1 + v.ad)  data_addr_ok = 1'b0;
            else                              data_addr_ok = 1'($urandom % 2);
            if (k == t_ok)                         data_data_ok = 1'b1;
            else if (k <= 1 + v.ad || k > t_ok)    data_data_ok = 1'($urandom % 2);
            else                                   data_data_ok = 1'b0;
            if (k < t_ok)       ext_stall = 1'($urandom % 2);
            else if (k == t_ok) ext_stall = (v.es > 0);
            else                ext_stall = (k < t_ok + 1 + v.es);
            data_rdata = (k == t_ok) ? v.rdata : $urandom;
            @(negedge clk);
            chk("stall", data_stall_M, (k < t_ok) ? 1 : ((k == t_ok) ? !skip_done : 0));
            chk("req", data_req, (k >= 1 && k <= 1 + v.ad) ? 1 : 0);
            stalls += int'(data_stall_M);
            reqs   += int'(data_req);
            if (k == 0) chk("rdata_before", mem_rdata_M, m_rdata_q);
            if (data_req) begin
                chk("bus_addr", data_addr, v.addr);
                chk("bus_wr", data_wr, wr);
                chk("bus_size", data_size, v.size);
                chk("bus_wdata", data_wdata, v.wdata);
            end
            if (k == t_ok && skip_done && !wr) chk("fwd_rdata", mem_rdata_M, v.rdata);
            if (k > t_ok) chk("done_rdata", mem_rdata_M, new_q);
        end
        m_rdata_q = new_q;
        chk("stall_cycles", stalls, skip_done ? t_ok : t_ok + 1);
        chk("req_cycles", reqs, v.ad + 1);
    endtask

    vec_t tbl[5];
    vec_t rv;

    initial begin
        resetn = 1'b0; mem_en_M = 1'b0; mem_wen_M = 4'h0; mem_size_M = 2'd0;
        mem_addr_M = 32'h0; mem_wdata_M = 32'h0; except_M = 1'b0; ext_stall = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'h0;

        tbl[0] = '{en:1, exc:0, wen:4'h0, size:2'd2, addr:32'h1000, wdata:32'h0,
                   rdata:32'hDEADBEEF, ad:0, dd:0, es:0};
        tbl[1] = '{en:1, exc:0, wen:4'b0011, size:2'd1, addr:32'h2002, wdata:32'h0000_A5A5,
                   rdata:32'h1234_5678, ad:4, dd:1, es:0};
        tbl[2] = '{en:1, exc:0, wen:4'h0, size:2'd0, addr:32'h3001, wdata:32'h0,
                   rdata:32'hCAFE_F00D, ad:1, dd:2, es:6};
        tbl[3] = '{en:1, exc:1, wen:4'h0, size:2'd2, addr:32'h4000, wdata:32'h0,
                   rdata:32'h0BAD_0BAD, ad:0, dd:0, es:0};
        tbl[4] = '{en:1, exc:0, wen:4'h0, size:2'd2, addr:32'h1000, wdata:32'h0,
                   rdata:32'hDEADBEEF, ad:0, dd:0, es:0};

        @(negedge clk);
        chk("rst_stall", data_stall_M, 0);
        chk("rst_req", data_req, 0);
        chk("rst_wr", data_wr, 0);
        chk("rst_size", data_size, 0);
        chk("rst_addr", data_addr, 0);
        chk("rst_wdata", data_wdata, 0);
        chk("rst_rdata", mem_rdata_M, 0);
        mem_en_M = 1'b1; #1;
        chk("rst_stall_issue", data_stall_M, 1);
        mem_en_M = 1'b0;
        @(posedge clk); #1; resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_vec(tbl[i]);

        // Reset pulsed while the load sits in DATA
        @(posedge clk); #1;
        mem_en_M = 1'b1; except_M = 1'b0; drive_fields(tbl[2]);
        data_addr_ok = 1'b0; data_data_ok = 1'b0; ext_stall = 1'b0;
        @(posedge clk); #1; data_addr_ok = 1'b1;
        @(posedge clk); #1; data_addr_ok = 1'b0;
        @(negedge clk);
        chk("pre_rst_stall", data_stall_M, 1);
        resetn = 1'b0; #1;
        chk("midrst_req", data_req, 0);
        chk("midrst_addr", data_addr, 0);
        chk("midrst_wr", data_wr, 0);
        chk("midrst_size", data_size, 0);
        chk("midrst_wdata", data_wdata, 0);
        chk("midrst_rdata", mem_rdata_M, 0);
        chk("midrst_stall", data_stall_M, 1);
        m_rdata_q = 32'h0;
        mem_en_M = 1'b0; #1;
        chk("midrst_stall_idle", data_stall_M, 0);
        @(posedge clk); #1; resetn = 1'b1;
        run_vec(tbl[0]);

        for (int i = 0; i < 200; i++) begin
            rv.en    = ($urandom % 8) != 0;
            rv.exc   = ($urandom % 6) == 0;
            rv.wen   = ($urandom % 2) ? 4'($urandom_range(1, 15)) : 4'h0;
            rv.size  = 2'($urandom_range(0, 2));
            rv.addr  = $urandom;
            rv.wdata = $urandom;
            rv.rdata = $urandom;
            rv.ad    = $urandom_range(0, 4);
            rv.dd    = $urandom_range(0, 4);
            rv.es    = $urandom_range(0, 3);
            run_vec(rv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
